// File: rtl/game_sequencer_pkg.sv
// ============================================================================
// Module  : game_sequencer_pkg
// Brief   : Shared FSM encoding and parameter defaults for the game sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package game_sequencer_pkg;

    localparam int DEF_DEB_CYCLES  = 4;
    localparam int DEF_HOLD_CYCLES = 8;
    localparam int DEF_START_LIVES = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_HOLD   = 3'd2,
        ST_RESULT = 3'd3,
        ST_OVER   = 3'd4
    } state_t;

    // Counter width for a counter spanning 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/game_sequencer_btn_debounce.sv
// ============================================================================
// Module  : btn_debounce
// Brief   : 2-flop synchronizer, debounce counter and rising-edge press pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import game_sequencer_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Button,
    output logic Press
);

    localparam int CW = cnt_width(DEB_CYCLES);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // The level flips on the DEB_CYCLES-th consecutive differing sample.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= Button;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign Press = press_q;

endmodule

`default_nettype wire

// File: rtl/game_sequencer.sv
// ============================================================================
// Module  : game_sequencer
// Brief   : Reaction-game round sequencer: stop/freeze control, score, lives.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int START_LIVES = DEF_START_LIVES
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Button,
    input  logic       Win,
    input  logic       Lose,
    output logic       Stop,
    output logic [3:0] Score,
    output logic [1:0] Lives,
    output logic       GameOver
);

    localparam int HW = cnt_width(HOLD_CYCLES);

    logic          press;
    state_t        state_q, state_d;
    logic [3:0]    score_q, score_d;
    logic [1:0]    lives_q, lives_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          stop_q, stop_d;
    logic          over_q, over_d;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .Clock  (Clock),
        .Reset  (Reset),
        .Button (Button),
        .Press  (press)
    );

    always_comb begin
        state_d = state_q;
        score_d = score_q;
        lives_d = lives_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (press) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (press) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // Judge outputs are sampled exactly once, on entry to RESULT.
                state_d = ST_RESULT;
                hold_d  = '0;
                if (Win && !Lose) begin
                    if (score_q != 4'd15) score_d = score_q + 4'd1;
                end else if (lives_q != 2'd0) begin
                    lives_d = lives_q - 2'd1;
                end
            end
            ST_RESULT: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    hold_d  = '0;
                    state_d = (lives_q == 2'd0) ? ST_OVER : ST_RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_OVER: begin
                if (press) begin
                    score_d = 4'd0;
                    lives_d = 2'(START_LIVES);
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Outputs are registered from the next state so they carry no input path.
        stop_d = (state_d != ST_RUN);
        over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            score_q <= 4'd0;
            lives_q <= 2'(START_LIVES);
            hold_q  <= '0;
            stop_q  <= 1'b1;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
            lives_q <= lives_d;
            hold_q  <= hold_d;
            stop_q  <= stop_d;
            over_q  <= over_d;
        end
    end

    assign Stop     = stop_q;
    assign Score    = score_q;
    assign Lives    = lives_q;
    assign GameOver = over_q;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// ============================================================================
// Module  : tb_game_sequencer
// Brief   : Directed, table-driven self-checking bench for game_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_sequencer;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Button;
    logic       Win;
    logic       Lose;
    logic       Stop;
    logic [3:0] Score;
    logic [1:0] Lives;
    logic       GameOver;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         restart;
        bit         win;
        bit         lose;
        logic [3:0] score;
        logic [1:0] lives;
        bit         stop;
        bit         over;
    } vec_t;

    vec_t vecs[21];

    always #5 Clock = ~Clock;

    game_sequencer dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Button   (Button),
        .Win      (Win),
        .Lose     (Lose),
        .Stop     (Stop),
        .Score    (Score),
        .Lives    (Lives),
        .GameOver (GameOver)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Press in RUN, judge result sampled one cycle later, then the freeze.
    task automatic play_round(input bit w, input bit l);
        Win    = w;
        Lose   = l;
        Button = 1'b1;
        step(7);
        check("hold_stop", Stop, 1);
        step(1);
        Button = 1'b0;
        step(7);
        check("result_stop", Stop, 1);
        step(1);
    endtask

    task automatic restart_press();
        Button = 1'b1;
        step(7);
        Button = 1'b0;
        step(7);
    endtask

    initial begin
        int presses;
        int stops;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 4'd1, 2'd2, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 4'd1, 2'd1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 4'd1, 2'd0, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 4'd0, 2'd3, 1'b0, 1'b0};
        for (int i = 4; i < 20; i++)
            vecs[i] = '{1'b0, 1'b1, 1'b0, 4'(((i - 3) > 15) ? 15 : (i - 3)), 2'd3, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 4'd15, 2'd2, 1'b0, 1'b0};

        // Reset state
        Reset  = 1'b0;
        Button = 1'b0;
        Win    = 1'b0;
        Lose   = 1'b0;
        step(2);
        check("rst_stop", Stop, 1);
        check("rst_score", Score, 0);
        check("rst_lives", Lives, 3);
        check("rst_over", GameOver, 0);
        Reset = 1'b1;
        step(1);

        // Clean press: pulse 6 cycles after Button rises, IDLE -> RUN
        Button = 1'b1;
        step(5);
        check("press_early", dut.u_debounce.Press, 0);
        step(1);
        check("press_lat", dut.u_debounce.Press, 1);
        check("idle_stop", Stop, 1);
        step(1);
        check("press_single", dut.u_debounce.Press, 0);
        check("run_stop", Stop, 0);
        Button = 1'b0;
        step(8);

        // Bouncing press in RUN with Win=1
        Win     = 1'b1;
        Lose    = 1'b0;
        presses = 0;
        stops   = 0;
        for (int i = 0; i < 4; i++) begin
            Button = (i % 2 == 0);
            step(1);
            presses += int'(dut.u_debounce.Press);
            stops   += int'(Stop);
        end
        Button = 1'b1;
        for (int i = 0; i < 25; i++) begin
            step(1);
            presses += int'(dut.u_debounce.Press);
            stops   += int'(Stop);
        end
        check("bounce_presses", 8'(presses), 1);
        check("bounce_stop_cycles", 8'(stops), 9);
        check("bounce_score", Score, 1);
        check("bounce_stop_after", Stop, 0);
        check("bounce_lives", Lives, 3);
        Button = 1'b0;
        step(8);

        // Table: lose rounds to game over, restart, 16 wins, win+lose together
        for (int i = 0; i < 21; i++) begin
            if (vecs[i].restart) restart_press();
            else                 play_round(vecs[i].win, vecs[i].lose);
            check($sformatf("vec%0d_score", i), Score, vecs[i].score);
            check($sformatf("vec%0d_lives", i), Lives, vecs[i].lives);
            check($sformatf("vec%0d_stop", i), Stop, vecs[i].stop);
            check($sformatf("vec%0d_over", i), GameOver, vecs[i].over);
        end

        // Second press landing inside RESULT is discarded
        Win    = 1'b0;
        Lose   = 1'b1;
        Button = 1'b1;
        step(4);
        Button = 1'b0;
        step(4);
        check("res_stop", Stop, 1);
        check("res_lives", Lives, 1);
        Button = 1'b1;
        step(6);
        check("res_press_seen", dut.u_debounce.Press, 1);
        step(2);
        check("res_no_hold", Stop, 0);
        step(3);
        check("res_no_hold_late", Stop, 0);
        check("res_score", Score, 15);
        check("res_lives_after", Lives, 1);
        Button = 1'b0;
        step(8);

        // Asynchronous reset in RESULT
        Win    = 1'b1;
        Lose   = 1'b0;
        Button = 1'b1;
        step(8);
        Button = 1'b0;
        step(3);
        check("pre_rst_stop", Stop, 1);
        #2;
        Reset = 1'b0;
        #1;
        check("arst_stop", Stop, 1);
        check("arst_score", Score, 0);
        check("arst_lives", Lives, 3);
        check("arst_over", GameOver, 0);
        step(2);
        Reset = 1'b1;
        step(8);
        check("post_rst_idle", Stop, 1);
        check("post_rst_score", Score, 0);
        Button = 1'b1;
        step(7);
        check("post_rst_run", Stop, 0);
        Button = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter DEB_CYCLES, default 4: consecutive stable synchronized samples required to accept a Button level change.
REQ-002 Parameter HOLD_CYCLES, default 8: cycles the Stop freeze is held after a round result is latched.
REQ-003 Parameter START_LIVES, default 3: lives loaded at reset and at game restart; range 1..3.
REQ-004 Clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset; Reset=0 forces reset state immediately, independent of Clock.
REQ-006 Button  input  1  raw player stop button, asynchronous to Clock, active-high, may bounce.
REQ-007 Win  input  1  round-win flag from the win/lose judge, valid while Stop=1.
REQ-008 Lose  input  1  round-lose flag from the win/lose judge, valid while Stop=1.
REQ-009 Stop  output  1  freeze request to the judge and the up/down counters; 1 = counters halted, result requested.
REQ-010 Score  output  4  number of rounds won, unsigned.
REQ-011 Lives  output  2  remaining lives, unsigned.
REQ-012 GameOver  output  1  1 while the game has ended and is waiting for a restart press.

Function
REQ-013 Button SHALL pass through a 2-flop synchronizer, then a debounce counter; the debounced level SHALL change only after DEB_CYCLES consecutive equal synchronized samples differing from it.
REQ-014 A press event SHALL be a single-cycle pulse on the 0->1 transition of the debounced level; holding Button SHALL generate no further events.
REQ-015 Press-to-event latency SHALL be 2 + DEB_CYCLES cycles for a clean edge.
REQ-016 FSM states SHALL be IDLE, RUN, HOLD, RESULT, OVER.
REQ-017 IDLE: Stop=1, GameOver=0; a press event SHALL move to RUN.
REQ-018 RUN: Stop=0; a press event SHALL move to HOLD.
REQ-019 HOLD: Stop=1; lasts exactly one cycle, so the judge sees Stop for one full cycle before sampling; then moves to RESULT.
REQ-020 On entry to RESULT, Win and Lose SHALL be sampled once: Win=1, Lose=0 -> Score+1; every other combination (Lose=1, both 1, both 0) -> Lives-1.
REQ-021 Score SHALL saturate at 15; further wins SHALL leave it at 15.
REQ-022 RESULT SHALL hold Stop=1 for HOLD_CYCLES cycles, then go to OVER if Lives=0, otherwise to RUN.
REQ-023 OVER: Stop=1, GameOver=1; a press event SHALL reload Score=0 and Lives=START_LIVES, clear GameOver, and move to RUN.
REQ-024 Press events in HOLD or RESULT SHALL be discarded, not queued.
REQ-025 Stop, Score, Lives and GameOver SHALL be driven directly from registers, with no combinational path from any input.

Reset
REQ-026 While Reset=0: state=IDLE, Stop=1, Score=0, Lives=START_LIVES, GameOver=0, synchronizer flops=0, debounced level=0, debounce and hold counters=0.
REQ-027 Reset asserted mid-round, in any state, SHALL abort the round with no score or life update; after release, operation resumes from IDLE.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding and the default values of DEB_CYCLES, HOLD_CYCLES and START_LIVES.
REQ-029 Synchronizer, debounce and edge detection SHALL be one sub-module, btn_debounce, with ports Clock, Reset, Button and Press.
REQ-030 Both counters SHALL be sized from their parameters, and the hold counter SHALL be no wider than required.

Verification
REQ-031 Reset release, then Button=1 steady -> one Press pulse 6 cycles later; IDLE->RUN; Stop goes 1->0.
REQ-032 In RUN, Button bounces 1,0,1,0 with 1-cycle widths, then stays 1 -> exactly one press event; Stop=1 for 1+8 cycles; Win=1 -> Score 0->1; Stop returns to 0.
REQ-033 Three rounds with Lose=1 -> Lives 3->2->1->0; GameOver=1 and Stop=1 after the third RESULT; next press -> Score=0, Lives=3, RUN.
REQ-034 Win=1 and Lose=1 together at the sample point -> Lives decrements and Score is unchanged; 16 wins -> Score stays at 15.
REQ-035 Press during RESULT -> ignored, no extra HOLD; Reset=0 pulsed in RESULT -> immediate IDLE, Score and Lives at reset values, no update.
